// File: rtl/zwolf_spi_sram.sv
// -----------------------------------------------------------------------------
// zwolf_spi_sram
//
// Memory-side responder for the Zwolf CPU bus. Each CPU request (13-bit byte
// address, 8-bit data) becomes one single-byte READ (0x03) or WRITE (0x02)
// frame to an external 8 KiB SPI SRAM in SPI mode 0. After reset the SRAM is
// optionally put into byte mode with WRSR 0x01,0x00. Completion goes back to the
// CPU on a level-held four-phase handshake: mem_ready stays high for as long as
// mem_valid stays high once the frame has finished.
//
// Parameters
//   CLK_DIV   : clk cycles per SCK half-period (>= 1)
//   CS_GAP    : minimum clk cycles spi_cs_n stays high between frames (>= 1)
//   INIT_MODE : 1 = issue WRSR byte-mode frame after reset, 0 = skip it
//
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   mem_addr   in   byte address, stable while mem_valid is high
//   mem_wdata  in   write data, stable while mem_valid is high
//   mem_write  in   1 = write, 0 = read
//   mem_valid  in   request strobe from the CPU
//   mem_ready  out  completion, ack_q qualified by mem_valid
//   mem_rdata  out  registered read data
//   spi_cs_n   out  SRAM chip select, active low
//   spi_sck    out  SPI clock, idles low
//   spi_mosi   out  serial data to SRAM, MSB first
//   spi_miso   in   serial data from SRAM
// -----------------------------------------------------------------------------
module zwolf_spi_sram #(
    parameter int CLK_DIV   = 2,
    parameter int CS_GAP    = 4,
    parameter int INIT_MODE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [12:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    input  logic        mem_write,
    input  logic        mem_valid,
    output logic        mem_ready,
    output logic [7:0]  mem_rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(CS_GAP + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP);

    // WRSR 0x01 with status 0x00 (byte mode), left-aligned in the shifter
    localparam logic [31:0] INIT_FRAME = 32'h0100_0000;

    typedef enum logic [2:0] {
        ST_GAP  = 3'd0,
        ST_INIT = 3'd1,
        ST_IDLE = 3'd2,
        ST_XFER = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam state_t RESET_TARGET = (INIT_MODE != 0) ? ST_INIT : ST_IDLE;

    // Builds the 32-bit command frame; address bits [15:13] are always zero.
    function automatic logic [31:0] build_frame(input logic        wr,
                                                input logic [12:0] addr,
                                                input logic [7:0]  wdata);
        logic [31:0] frame;
        if (wr) begin
            frame = {8'h02, 3'b000, addr, wdata};
        end else begin
            frame = {8'h03, 3'b000, addr, 8'h00};
        end
        return frame;
    endfunction

    state_t            state_q,  state_d;
    state_t            target_q, target_d;
    logic [GAP_W-1:0]  gap_q,    gap_d;
    logic [DIV_W-1:0]  div_q,    div_d;
    logic [4:0]        bit_q,    bit_d;
    logic              sck_q,    sck_d;
    logic              cs_n_q,   cs_n_d;
    logic [31:0]       shift_q,  shift_d;
    logic [7:0]        rx_q,     rx_d;
    logic [7:0]        rdata_q,  rdata_d;
    logic              ack_q,    ack_d;
    logic              rd_q,     rd_d;

    logic [31:0]       frame_s;
    logic [4:0]        last_bit_s;

    // State register and all datapath registers; reset aborts any frame at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_GAP;
            target_q <= RESET_TARGET;
            gap_q    <= '0;
            div_q    <= '0;
            bit_q    <= 5'd0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            shift_q  <= 32'h0000_0000;
            rx_q     <= 8'h00;
            rdata_q  <= 8'h00;
            ack_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            gap_q    <= gap_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sck_q    <= sck_d;
            cs_n_q   <= cs_n_d;
            shift_q  <= shift_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            rd_q     <= rd_d;
        end
    end

    // Next-state logic: gap timing, frame launch, bit engine and handshake.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        gap_d      = gap_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        ack_d      = ack_q;
        rd_d       = rd_q;
        frame_s    = build_frame(mem_write, mem_addr, mem_wdata);
        last_bit_s = (state_q == ST_INIT) ? 5'd15 : 5'd31;

        case (state_q)
            ST_GAP: begin
                // The count starts at zero on entry, so CS stays high for at
                // least CS_GAP full cycles before the next frame can start.
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (target_q == ST_INIT) begin
                        state_d = ST_INIT;
                        shift_d = INIT_FRAME;
                        cs_n_d  = 1'b0;
                        sck_d   = 1'b0;
                        div_d   = '0;
                        bit_d   = 5'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_IDLE: begin
                if (mem_valid) begin
                    state_d = ST_XFER;
                    shift_d = frame_s;
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = 5'd0;
                    rd_d    = ~mem_write;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_INIT, ST_XFER: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        // Rising SCK: capture MISO as it was before the rise.
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], spi_miso};
                    end else if (bit_q == last_bit_s) begin
                        // End of the final high phase closes the frame.
                        sck_d   = 1'b0;
                        cs_n_d  = 1'b1;
                        shift_d = 32'h0000_0000;
                        gap_d   = '0;
                        if (state_q == ST_INIT) begin
                            state_d  = ST_GAP;
                            target_d = ST_IDLE;
                        end else begin
                            state_d = ST_ACK;
                            ack_d   = 1'b1;
                            if (rd_q) begin
                                rdata_d = rx_q;
                            end else begin
                                rdata_d = rdata_q;
                            end
                        end
                    end else begin
                        // Falling SCK: present the next bit on MOSI.
                        sck_d   = 1'b0;
                        shift_d = {shift_q[30:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_ACK: begin
                // A still-high mem_valid only holds ready; it never relaunches.
                if (!mem_valid) begin
                    ack_d    = 1'b0;
                    state_d  = ST_GAP;
                    target_d = ST_IDLE;
                    gap_d    = '0;
                end else begin
                    state_d = ST_ACK;
                end
            end

            default: begin
                state_d  = ST_GAP;
                target_d = RESET_TARGET;
                gap_d    = '0;
                sck_d    = 1'b0;
                cs_n_d   = 1'b1;
                shift_d  = 32'h0000_0000;
                ack_d    = 1'b0;
            end
        endcase
    end

    assign mem_ready = ack_q & mem_valid;
    assign mem_rdata = rdata_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = shift_q[31];

endmodule

// File: doc/zwolf_spi_sram.md
Name: zwolf_spi_sram

Overview:
Memory-side responder for the Zwölf CPU memory bus. It accepts the CPU's 13-bit address / 8-bit data requests and completes each one as a single-byte READ or WRITE transaction to an external 8 KiB SPI SRAM (23LC64-class, SPI mode 0). On reset it programs the SRAM into byte mode. It returns read data and `mem_ready` to the CPU using a level-held four-phase handshake.

Parameters:
- CLK_DIV, 2: `clk` cycles per SCK half-period; must be ≥1.
- CS_GAP, 4: minimum `clk` cycles `spi_cs_n` stays high between frames, including the frame after reset.
- INIT_MODE, 1: 1 = send WRSR 0x01,0x00 (byte mode) after reset; 0 = go straight to IDLE after the CS_GAP wait.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- mem_addr  in  13  byte address; stable while `mem_valid` is high.
- mem_wdata  in  8  write data; stable while `mem_valid` is high.
- mem_write  in  1  1 = write, 0 = read; stable while `mem_valid` is high.
- mem_valid  in  1  request strobe from the CPU.
- mem_ready  out  1  completion; combinational `ack_q & mem_valid`.
- mem_rdata  out  8  read data, registered.
- spi_cs_n  out  1  SRAM chip select, active low.
- spi_sck  out  1  SPI clock, idles low.
- spi_mosi  out  1  serial data to SRAM, MSB first.
- spi_miso  in  1  serial data from SRAM.

Behaviour:
- Reset values (async, while `resetn`=0):
  - `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `mem_rdata`=0x00, `ack_q`=0, so `mem_ready`=0.
  - state=GAP with target INIT (or IDLE if INIT_MODE=0).
- States: GAP, INIT, IDLE, XFER, ACK.
- GAP:
  - Hold `cs_n`=1 for CS_GAP cycles, then go to the pending target.
  - `mem_valid` is ignored in GAP.
- INIT:
  - Shift 16 bits, 0x01 then 0x00, with framing identical to XFER.
  - Then go to GAP with target IDLE.
  - Requests arriving during GAP or INIT stay pending; they are not dropped.
- IDLE:
  - When `mem_valid`=1, latch a 32-bit frame into the shift register:
    - {0x03, 3'b000, mem_addr, 8'h00} if `mem_write`=0;
    - {0x02, 3'b000, mem_addr, mem_wdata} if `mem_write`=1.
  - On that same edge: `cs_n`→0, `sck`=0, `mosi`=frame[31]; go to XFER.
- XFER (per bit):
  - SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the edge where SCK rises, sample `spi_miso` into an 8-bit input shifter.
  - On the edge where SCK falls, present the next bit on MOSI.
  - Frame is exactly 32 bits (16 bits in INIT); the bit counter is 5 bits.
- Frame end:
  - On the edge that ends the high phase of the last bit: `sck`→0, `cs_n`→1.
  - For a read, `mem_rdata` ← the last 8 sampled bits; for a write, `mem_rdata` is unchanged.
  - `ack_q`→1; go to ACK.
  - Latency: `mem_ready` is first high in the cycle after edge A+64·CLK_DIV, where A is the accepting edge (A+128 at default).
- ACK:
  - `mem_ready` = `mem_valid`; it is held, not pulsed, so a CPU sampling late still sees it.
  - `mem_rdata` is stable throughout ACK.
  - When `mem_valid`=0: `ack_q`→0, go to GAP with target IDLE.
  - A still-high `mem_valid` never starts a second frame.
  - `mem_ready` falls in the same cycle `mem_valid` falls (combinational qualify).
- Back-to-back requests: the next CS fall comes at least CS_GAP+1 cycles after the previous CS rise.
- Request fields are sampled only at acceptance. Changes to them during XFER are ignored.
- `mem_valid` dropping during XFER:
  - The frame completes (a write is still performed).
  - `ack_q` is set, `mem_ready` stays 0, and ACK exits on the next cycle.
- Reset mid-frame:
  - CS rises immediately (async).
  - The SRAM command is aborted and init reruns; no `mem_ready` is issued for the aborted request.
- Address bits [15:13] of the frame are always 0.

Test Plan:
- Init sequence: release reset; MOSI capture → CS high ≥4 cycles, then one 16-bit frame 0x01 0x00, SCK idle low, CS high again ≥4 cycles.
- Read: `mem_valid`=1 with addr 0x1ABC, `write`=0; SRAM model drives 0x5A → MOSI frame 03 1A BC 00, `mem_rdata`=0x5A, `mem_ready` first high exactly 128 cycles after acceptance.
- Write then read-back: write 0xA5 to 0x1FFF (frame 02 1F FF A5), then read 0x1FFF → 0xA5; the `mem_rdata` value from before the write is unchanged after the write completes.
- Handshake hold: keep `mem_valid` high 50 cycles after ready → `mem_ready` stays 1, CS stays high, no new frame; drop valid → `mem_ready` 0 in the same cycle.
- Early request: assert `mem_valid` during INIT → no SPI activity for it until init plus CS_GAP complete, then a correct frame and ready.
- Reset mid-XFER at bit 12 → `spi_cs_n`=1 and `spi_sck`=0 immediately, `mem_ready`=0, init frame reissued after release.
